add_accumulator: RTL and testbench

- Accumulator/sequencer stage wrapped around the 4-bit combinational adder.
- Buffers incoming nibble operands in a small FIFO and drives the adder's two operand inputs: accumulator on one, FIFO head on the other.
- Captures the adder's sum, carry and zero results back into the accumulator and flag registers, one addition per clock.
- Signals run completion to the controller with a START/BUSY/DONE handshake.

---
 rtl/add_accumulator.sv | 140 ++++++++++++++
 tb/tb_add_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/add_accumulator.sv
// Accumulator/sequencer around a combinational 4-bit adder: queues operand nibbles,
// feeds accumulator and FIFO head to the adder, and captures its results one per clock.
module add_accumulator #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [3:0]       din,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   input  logic             start,
   input  logic             clr,
   output logic             busy,
   output logic             done,
   output logic [3:0]       acc,
   output logic             cf_last,
   output logic             cf_sticky,
   output logic             z,
   output logic [3:0]       run_cnt,
   output logic [3:0]       a_out,
   output logic [3:0]       b_out,
   input  logic [3:0]       sum_in,
   input  logic             cf_in,
   input  logic             z_in
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt_q;
   logic             push_ok;
   logic             pop;

   // Occupancy flags come straight from the counter register
   assign count   = cnt_q;
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);

   // FULL is judged before the pop, so a push at full is dropped even when popping
   assign push_ok = push && !full;
   assign pop     = (state == S_EXEC) && !empty;

   assign a_out   = acc;
   assign b_out   = pop ? mem[rd_ptr] : 4'd0;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = empty ? S_DONE : S_EXEC;
         end
         S_EXEC: begin
            if (empty || (cnt_q == CNT_W'(1) && !push_ok)) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state register
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         S_EXEC:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Operand FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop)      cnt_q <= cnt_q + CNT_W'(1);
         else if (pop && !push_ok) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Accumulator, flags and run counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= 4'd0;
         cf_last   <= 1'b0;
         cf_sticky <= 1'b0;
         z         <= 1'b0;
         run_cnt   <= 4'd0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (clr) begin
                  acc       <= 4'd0;
                  cf_last   <= 1'b0;
                  cf_sticky <= 1'b0;
                  z         <= 1'b0;
               end
               if (start) run_cnt <= 4'd0;
            end
            S_EXEC: begin
               if (pop) begin
                  acc       <= sum_in;
                  cf_last   <= cf_in;
                  z         <= z_in;
                  cf_sticky <= cf_sticky | cf_in;
                  if (run_cnt != 4'd15) run_cnt <= run_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add_accumulator.sv
// Directed bench for add_accumulator with a behavioural 4-bit adder in the loop.
module tb_add_accumulator;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             push;
   logic [3:0]       din;
   logic             full, empty;
   logic [CNT_W-1:0] count;
   logic             start, clr;
   logic             busy, done;
   logic [3:0]       acc;
   logic             cf_last, cf_sticky, z;
   logic [3:0]       run_cnt;
   logic [3:0]       a_out, b_out;
   logic [3:0]       sum_in;
   logic             cf_in, z_in;

   int errors = 0;
   int checks = 0;

   add_accumulator #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .din(din), .full(full), .empty(empty),
      .count(count), .start(start), .clr(clr), .busy(busy), .done(done), .acc(acc),
      .cf_last(cf_last), .cf_sticky(cf_sticky), .z(z), .run_cnt(run_cnt),
      .a_out(a_out), .b_out(b_out), .sum_in(sum_in), .cf_in(cf_in), .z_in(z_in)
   );

   always #5 clk = ~clk;

   // Combinational adder model
   logic [4:0] add5;
   assign add5   = {1'b0, a_out} + {1'b0, b_out};
   assign sum_in = add5[3:0];
   assign cf_in  = add5[4];
   assign z_in   = (add5[3:0] == 4'd0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_val(input logic [3:0] v);
      push = 1'b1;
      din  = v;
      tick();
      push = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; push = 1'b0; din = 4'd0; start = 1'b0; clr = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      check("init_empty", 8'(empty), 8'd1);
      check("init_b_out", 8'(b_out), 8'd0);

      // Reset discards queued operands
      push_val(4'd3); push_val(4'd5);
      check("rst_pre_count", 8'(count), 8'd2);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("rst_empty", 8'(empty), 8'd1);
      check("rst_full", 8'(full), 8'd0);
      check("rst_count", 8'(count), 8'd0);
      check("rst_acc", 8'(acc), 8'd0);
      check("rst_a_out", 8'(a_out), 8'd0);
      check("rst_busy", 8'(busy), 8'd0);
      check("rst_b_out", 8'(b_out), 8'd0);
      start = 1'b1; tick(); start = 1'b0;
      check("empty_start_done", 8'(done), 8'd1);
      check("empty_start_busy", 8'(busy), 8'd0);
      check("empty_start_runcnt", 8'(run_cnt), 8'd0);
      tick();
      check("empty_done_pulse", 8'(done), 8'd0);

      // Basic run 3,4,5
      push_val(4'd3); push_val(4'd4); push_val(4'd5);
      start = 1'b1; tick(); start = 1'b0;
      check("basic_busy1", 8'(busy), 8'd1);
      check("basic_b1", 8'(b_out), 8'd3);
      tick();
      check("basic_acc1", 8'(acc), 8'd3);
      check("basic_busy2", 8'(busy), 8'd1);
      check("basic_b2", 8'(b_out), 8'd4);
      tick();
      check("basic_acc2", 8'(acc), 8'd7);
      check("basic_busy3", 8'(busy), 8'd1);
      tick();
      check("basic_acc3", 8'(acc), 8'd12);
      check("basic_done", 8'(done), 8'd1);
      check("basic_busy_off", 8'(busy), 8'd0);
      check("basic_sticky", 8'(cf_sticky), 8'd0);
      check("basic_z", 8'(z), 8'd0);
      check("basic_runcnt", 8'(run_cnt), 8'd3);
      tick();
      check("basic_done_off", 8'(done), 8'd0);

      // Carry / zero run 9,8,15
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr_acc", 8'(acc), 8'd0);
      push_val(4'd9); push_val(4'd8); push_val(4'd15);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("cz_acc1", 8'(acc), 8'd9);
      check("cz_cf1", 8'(cf_last), 8'd0);
      check("cz_z1", 8'(z), 8'd0);
      tick();
      check("cz_acc2", 8'(acc), 8'd1);
      check("cz_cf2", 8'(cf_last), 8'd1);
      check("cz_z2", 8'(z), 8'd0);
      tick();
      check("cz_acc3", 8'(acc), 8'd0);
      check("cz_cf3", 8'(cf_last), 8'd1);
      check("cz_z3", 8'(z), 8'd1);
      check("cz_sticky", 8'(cf_sticky), 8'd1);
      check("cz_done", 8'(done), 8'd1);
      tick();

      // FIFO full: fifth push dropped
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr_sticky", 8'(cf_sticky), 8'd0);
      push = 1'b1;
      din = 4'd1; tick();
      din = 4'd2; tick();
      din = 4'd3; tick();
      check("full_before", 8'(full), 8'd0);
      din = 4'd4; tick();
      check("full_set", 8'(full), 8'd1);
      check("full_count4", 8'(count), 8'd4);
      din = 4'd5; tick();
      push = 1'b0;
      check("full_drop_count", 8'(count), 8'd4);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick(); tick();
      check("full_acc", 8'(acc), 8'd10);
      check("full_runcnt", 8'(run_cnt), 8'd4);
      check("full_done", 8'(done), 8'd1);
      tick();

      // Push during run, with CLR+START together in IDLE
      push_val(4'd2);
      clr = 1'b1; start = 1'b1; tick(); clr = 1'b0; start = 1'b0;
      check("pdr_acc_cleared", 8'(acc), 8'd0);
      check("pdr_b1", 8'(b_out), 8'd2);
      push = 1'b1; din = 4'd6; tick(); push = 1'b0;
      check("pdr_acc1", 8'(acc), 8'd2);
      check("pdr_stay_busy", 8'(busy), 8'd1);
      check("pdr_count", 8'(count), 8'd1);
      tick();
      check("pdr_acc2", 8'(acc), 8'd8);
      check("pdr_done", 8'(done), 8'd1);
      check("pdr_runcnt", 8'(run_cnt), 8'd2);
      tick();

      // CLR/START ignored in EXEC and DONE
      clr = 1'b1; tick(); clr = 1'b0;
      push_val(4'd1); push_val(4'd2); push_val(4'd3);
      start = 1'b1; tick();
      clr = 1'b1;
      tick();
      check("ign_acc1", 8'(acc), 8'd1);
      tick();
      check("ign_acc2", 8'(acc), 8'd3);
      tick();
      check("ign_acc3", 8'(acc), 8'd6);
      check("ign_done", 8'(done), 8'd1);
      tick();
      check("ign_done_clr", 8'(acc), 8'd6);
      check("ign_idle", 8'(busy | done), 8'd0);
      clr = 1'b0; start = 1'b0;

      // Reset in the second EXEC cycle
      push_val(4'd4); push_val(4'd4); push_val(4'd4);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("midrst_acc1", 8'(acc), 8'd10);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("midrst_busy", 8'(busy), 8'd0);
      check("midrst_done", 8'(done), 8'd0);
      check("midrst_acc", 8'(acc), 8'd0);
      check("midrst_empty", 8'(empty), 8'd1);
      check("midrst_runcnt", 8'(run_cnt), 8'd0);
      check("midrst_flags", 8'({cf_last, cf_sticky, z}), 8'd0);
      check("midrst_b_out", 8'(b_out), 8'd0);
      tick();
      check("midrst_no_done", 8'(done), 8'd0);

      // RUN_CNT saturation on a long run fed by pushes during EXEC
      push_val(4'd1);
      start = 1'b1; tick(); start = 1'b0;
      push = 1'b1; din = 4'd0;
      for (int i = 0; i < 17; i++) tick();
      check("sat_runcnt", 8'(run_cnt), 8'd15);
      check("sat_busy", 8'(busy), 8'd1);
      push = 1'b0;
      tick();
      check("sat_done", 8'(done), 8'd1);
      check("sat_runcnt_end", 8'(run_cnt), 8'd15);
      check("sat_acc", 8'(acc), 8'd1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
